// File: rtl/guess_game_ctrl.sv
// Number-guessing game sequencer: loads the secret, accepts one guess per
// button press, tracks attempts and drives the result flags and end states.
module guess_game_ctrl #(
    parameter int MAX_TRIES   = 8,
    parameter int RESULT_HOLD = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       secret_load,
    input  logic [3:0] secret_value,
    input  logic       guess_submitted,
    input  logic [3:0] player_guess,
    output logic [2:0] state,
    output logic       too_low,
    output logic       too_high,
    output logic       correct,
    output logic [3:0] attempts,
    output logic       busy
);

    localparam int unsigned HW = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD + 1) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        SHOW = 3'd2,
        WIN  = 3'd3,
        LOSE = 3'd4
    } state_t;

    state_t         state_r, state_n;
    logic [3:0]     secret, secret_n;
    logic           sub_d;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [3:0]     attempts_n;
    logic           low_n, high_n, correct_n;
    logic           guess_evt;

    assign state     = state_r;
    assign guess_evt = guess_submitted & ~sub_d;

    always_comb begin
        state_n    = state_r;
        secret_n   = secret;
        hold_n     = hold_cnt;
        attempts_n = attempts;
        low_n      = too_low;
        high_n     = too_high;
        correct_n  = correct;

        // A load pre-empts everything, including a guess edge in the same cycle.
        if (secret_load) begin
            secret_n   = secret_value;
            attempts_n = '0;
            low_n      = 1'b0;
            high_n     = 1'b0;
            correct_n  = 1'b0;
            hold_n     = '0;
            state_n    = PLAY;
        end else begin
            case (state_r)
                PLAY: begin
                    if (guess_evt) begin
                        attempts_n = attempts + 4'd1;
                        low_n      = player_guess < secret;
                        high_n     = player_guess > secret;
                        correct_n  = player_guess == secret;
                        if (player_guess == secret) begin
                            state_n = WIN;
                        end else if (attempts + 4'd1 == 4'(MAX_TRIES)) begin
                            state_n = LOSE;
                        end else begin
                            state_n = SHOW;
                            hold_n  = '0;
                        end
                    end
                end
                SHOW: begin
                    if (hold_cnt == HW'(RESULT_HOLD - 1)) begin
                        state_n = PLAY;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            secret   <= '0;
            sub_d    <= 1'b0;
            hold_cnt <= '0;
            attempts <= '0;
            too_low  <= 1'b0;
            too_high <= 1'b0;
            correct  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_n;
            secret   <= secret_n;
            sub_d    <= guess_submitted;
            hold_cnt <= hold_n;
            attempts <= attempts_n;
            too_low  <= low_n;
            too_high <= high_n;
            correct  <= correct_n;
            busy     <= (state_n == SHOW);
        end
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed, table-driven bench for guess_game_ctrl (MAX_TRIES=3, RESULT_HOLD=4).
module tb_guess_game_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       secret_load;
    logic [3:0] secret_value;
    logic       guess_submitted;
    logic [3:0] player_guess;
    logic [2:0] state;
    logic       too_low, too_high, correct, busy;
    logic [3:0] attempts;

    int errors = 0;
    int checks = 0;

    guess_game_ctrl #(.MAX_TRIES(3), .RESULT_HOLD(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .secret_load     (secret_load),
        .secret_value    (secret_value),
        .guess_submitted (guess_submitted),
        .player_guess    (player_guess),
        .state           (state),
        .too_low         (too_low),
        .too_high        (too_high),
        .correct         (correct),
        .attempts        (attempts),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic [3:0] sval;
        logic       sub;
        logic [3:0] g;
        logic [2:0] st;
        logic       lo, hi, co;
        logic [3:0] att;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic load, input logic [3:0] sval, input logic sub,
                       input logic [3:0] g, input logic [2:0] st, input logic lo,
                       input logic hi, input logic co, input logic [3:0] att,
                       input logic bsy);
        vec_t v;
        v.load = load; v.sval = sval; v.sub = sub; v.g = g; v.st = st;
        v.lo = lo; v.hi = hi; v.co = co; v.att = att; v.bsy = bsy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [2:0] st, input logic lo,
                           input logic hi, input logic co, input logic [3:0] att,
                           input logic bsy);
        chk("state",    idx, int'(state),    int'(st));
        chk("too_low",  idx, int'(too_low),  int'(lo));
        chk("too_high", idx, int'(too_high), int'(hi));
        chk("correct",  idx, int'(correct),  int'(co));
        chk("attempts", idx, int'(attempts), int'(att));
        chk("busy",     idx, int'(busy),     int'(bsy));
    endtask

    initial begin
        // load  sval sub  g     st lo hi co att bsy
        add(1, 9, 0, 0,  1, 0, 0, 0, 0, 0);  // 0 load 9
        add(0, 0, 1, 3,  2, 1, 0, 0, 1, 1);  // 1 guess 3 -> SHOW
        add(0, 0, 0, 0,  2, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0,  2, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0,  2, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0,  1, 1, 0, 0, 1, 0);  // 5 back to PLAY, flag kept
        add(1, 9, 0, 0,  1, 0, 0, 0, 0, 0);  // 6 new game
        add(0, 0, 1, 12, 2, 0, 1, 0, 1, 1);  // 7 held 12 for 10 cycles
        add(0, 0, 1, 12, 2, 0, 1, 0, 1, 1);
        add(0, 0, 1, 12, 2, 0, 1, 0, 1, 1);
        add(0, 0, 1, 12, 2, 0, 1, 0, 1, 1);
        add(0, 0, 1, 12, 1, 0, 1, 0, 1, 0);  // 11
        for (int i = 0; i < 5; i++) add(0, 0, 1, 12, 1, 0, 1, 0, 1, 0);
        add(0, 0, 0, 0,  1, 0, 1, 0, 1, 0);  // 17 release
        add(0, 0, 1, 9,  3, 0, 0, 1, 2, 0);  // 18 WIN
        add(0, 0, 0, 0,  3, 0, 0, 1, 2, 0);
        add(0, 0, 1, 4,  3, 0, 0, 1, 2, 0);  // 20 ignored in WIN
        add(0, 0, 0, 0,  3, 0, 0, 1, 2, 0);
        add(1, 5, 0, 0,  1, 0, 0, 0, 0, 0);  // 22 lose game, secret 5
        add(0, 0, 1, 1,  2, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 2, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0,  1, 1, 0, 0, 1, 0);  // 27
        add(0, 0, 1, 2,  2, 1, 0, 0, 2, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 2, 1, 0, 0, 2, 1);
        add(0, 0, 0, 0,  1, 1, 0, 0, 2, 0);  // 32
        add(0, 0, 1, 3,  4, 1, 0, 0, 3, 0);  // 33 LOSE
        add(0, 0, 0, 0,  4, 1, 0, 0, 3, 0);
        add(0, 0, 1, 5,  4, 1, 0, 0, 3, 0);  // 35 ignored in LOSE
        add(0, 0, 0, 0,  4, 1, 0, 0, 3, 0);
        add(1, 0, 0, 0,  1, 0, 0, 0, 0, 0);  // 37 load 0 from LOSE
        add(0, 0, 1, 0,  3, 0, 0, 1, 1, 0);
        add(0, 0, 0, 0,  3, 0, 0, 1, 1, 0);
        add(1, 8, 0, 0,  1, 0, 0, 0, 0, 0);  // 40 press during SHOW
        add(0, 0, 1, 2,  2, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0,  2, 1, 0, 0, 1, 1);
        add(0, 0, 1, 15, 2, 1, 0, 0, 1, 1);  // 43 ignored
        add(0, 0, 0, 0,  2, 1, 0, 0, 1, 1);
        add(0, 0, 0, 0,  1, 1, 0, 0, 1, 0);  // 45
        add(0, 0, 0, 0,  1, 1, 0, 0, 1, 0);
        add(1, 7, 1, 3,  1, 0, 0, 0, 0, 0);  // 47 load beats guess edge
        add(0, 0, 1, 3,  1, 0, 0, 0, 0, 0);  // still held: no event
        add(0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 7,  3, 0, 0, 1, 1, 0);  // 50 WIN

        rst = 1'b1; secret_load = 1'b0; secret_value = '0;
        guess_submitted = 1'b0; player_guess = '0;
        @(posedge clk); #1;
        chk_all(-1, 3'd0, 0, 0, 0, 4'd0, 0);
        @(negedge clk); rst = 1'b0;
        guess_submitted = 1'b1; player_guess = 4'd4;
        @(posedge clk); #1;
        chk("idle_ignores_guess", -2, int'(state), 0);
        @(negedge clk); guess_submitted = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            secret_load     = vecs[i].load;
            secret_value    = vecs[i].sval;
            guess_submitted = vecs[i].sub;
            player_guess    = vecs[i].g;
            @(posedge clk); #1;
            chk_all(i, vecs[i].st, vecs[i].lo, vecs[i].hi, vecs[i].co,
                    vecs[i].att, vecs[i].bsy);
        end

        // Asynchronous reset in the middle of SHOW
        @(negedge clk); secret_load = 1'b1; secret_value = 4'd2; guess_submitted = 1'b0;
        @(negedge clk); secret_load = 1'b0; guess_submitted = 1'b1; player_guess = 4'd1;
        @(posedge clk); #1;
        chk("pre_rst_state", 100, int'(state), 2);
        #2 rst = 1'b1;
        #1;
        chk_all(101, 3'd0, 0, 0, 0, 4'd0, 0);
        @(negedge clk); rst = 1'b0; guess_submitted = 1'b0;
        @(negedge clk); guess_submitted = 1'b1; player_guess = 4'd2;
        @(posedge clk); #1;
        chk_all(102, 3'd0, 0, 0, 0, 4'd0, 0);
        @(negedge clk); guess_submitted = 1'b0; secret_load = 1'b1; secret_value = 4'd2;
        @(posedge clk); #1;
        chk_all(103, 3'd1, 0, 0, 0, 4'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
